// File: rtl/tns_rx_checker_pkg.sv
// Shared TNS constants plus the per-group violation rule and codeword decode,
// reused by the checker, the decoder and any bench that wants them.
package tns_rx_checker_pkg;

    localparam int TNS_GW         = 3;
    localparam int TNS_RADIX      = 6;
    localparam int TNS_NGROUP_DEF = 2;
    localparam int TNS03_C        = 36;
    localparam int BLEN02         = 6;

    // A group may not rise into 3'b100 from a low top bit, nor fall into 3'b011 from a high one.
    function automatic logic tns_grp_viol(input logic [2:0] g, input logic prev);
        return ((g == 3'b100) && !prev) || ((g == 3'b011) && prev);
    endfunction

    // 3'b100 and 3'b011 are never emitted by the encoder; they decode to zero.
    function automatic logic [2:0] tns_grp_dec(input logic [2:0] g);
        logic [2:0] d;
        case (g)
            3'b000:  d = 3'd0;
            3'b001:  d = 3'd1;
            3'b010:  d = 3'd2;
            3'b101:  d = 3'd3;
            3'b110:  d = 3'd4;
            3'b111:  d = 3'd5;
            default: d = 3'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tns_rx_checker_dec.sv
// TNS_dec_06: combinational decoder that turns a TSV word back into data,
// treating each 3-bit group as one base-6 digit, most significant group first.
module TNS_dec_06
    import tns_rx_checker_pkg::*;
#(
    parameter int NGROUP = TNS_NGROUP_DEF,
    parameter int DLEN   = BLEN02
) (
    input  logic [TNS_GW*NGROUP-1:0] i_tsv,
    output logic [DLEN-1:0]          o_data
);

    always_comb begin
        o_data = '0;
        for (int j = NGROUP - 1; j >= 0; j--) begin
            o_data = (o_data * DLEN'(TNS_RADIX)) + DLEN'(tns_grp_dec(i_tsv[TNS_GW*j +: TNS_GW]));
        end
    end

endmodule

// File: rtl/tns_rx_checker.sv
// Receive-side TSV checker: captures the TSV word, decodes it, flags forbidden
// transitions per group and keeps a sticky flag and saturating error count.
module tns_rx_checker
    import tns_rx_checker_pkg::*;
#(
    parameter int NGROUP = TNS_NGROUP_DEF,
    parameter int DLEN   = BLEN02,
    parameter int ERRW   = 16
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic [TNS_GW*NGROUP-1:0] tsv_in,
    input  logic                     tsv_vld,
    input  logic                     err_clr,
    output logic [DLEN-1:0]          data_out,
    output logic                     data_vld,
    output logic [NGROUP-1:0]        viol,
    output logic                     err_sticky,
    output logic [ERRW-1:0]          err_cnt
);

    logic [TNS_GW*NGROUP-1:0] r_tsv;
    logic                     r_v1;
    logic [NGROUP-1:0]        r_prev;
    logic [DLEN-1:0]          r_data;
    logic                     r_vld;
    logic [NGROUP-1:0]        r_viol;
    logic                     r_sticky;
    logic [ERRW-1:0]          r_err_cnt;

    logic [NGROUP-1:0]        w_viol;
    logic [NGROUP-1:0]        w_top;
    logic [DLEN-1:0]          w_dec;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_tsv <= '0;
            r_v1  <= 1'b0;
        end else begin
            r_v1 <= tsv_vld;
            if (tsv_vld) begin
                r_tsv <= tsv_in;
            end
        end
    end

    // Each group is judged against the top bit it had in the previous valid word.
    for (genvar j = 0; j < NGROUP; j++) begin : g_check
        assign w_viol[j] = tns_grp_viol(r_tsv[TNS_GW*j +: TNS_GW], r_prev[j]);
        assign w_top[j]  = r_tsv[TNS_GW*j + TNS_GW - 1];
    end

    TNS_dec_06 #(
        .NGROUP (NGROUP),
        .DLEN   (DLEN)
    ) u_dec (
        .i_tsv  (r_tsv),
        .o_data (w_dec)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_data <= '0;
            r_vld  <= 1'b0;
            r_viol <= '0;
        end else begin
            r_vld <= r_v1;
            if (r_v1) begin
                r_prev <= w_top;
                r_data <= w_dec;
                r_viol <= w_viol;
            end
        end
    end

    // Clear takes priority over a violation landing on the same edge.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky  <= 1'b0;
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_sticky  <= 1'b0;
            r_err_cnt <= '0;
        end else if (r_v1 && (|w_viol)) begin
            r_sticky <= 1'b1;
            if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + ERRW'(1);
            end
        end
    end

    assign data_out   = r_data;
    assign data_vld   = r_vld;
    assign viol       = r_viol;
    assign err_sticky = r_sticky;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_tns_rx_checker.sv
// Bench for tns_rx_checker: directed and random TSV traffic compared against
// a word-level reference model of decode, violation rule and error counting.
module tb_tns_rx_checker;

    localparam int NG   = 2;
    localparam int DL   = 6;
    localparam int EW   = 4;
    localparam int CMAX = 15;

    logic          clock = 1'b0;
    logic          rst_n;
    logic [5:0]    tsv_in;
    logic          tsv_vld;
    logic          err_clr;
    logic [DL-1:0] data_out;
    logic          data_vld;
    logic [NG-1:0] viol;
    logic          err_sticky;
    logic [EW-1:0] err_cnt;

    int errors = 0;
    int checks = 0;

    logic       mV1;
    logic [5:0] mWord;
    logic [1:0] mPrev;
    logic       eVld;
    logic [1:0] eViol;
    int         eData;
    int         eCnt;
    logic       eSticky;

    logic [2:0] encTab [6] = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110, 3'b111};

    tns_rx_checker #(
        .NGROUP (NG),
        .DLEN   (DL),
        .ERRW   (EW)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .tsv_in     (tsv_in),
        .tsv_vld    (tsv_vld),
        .err_clr    (err_clr),
        .data_out   (data_out),
        .data_vld   (data_vld),
        .viol       (viol),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
    );

    always #5 clock = ~clock;

    function automatic logic [5:0] refEncode(input int v);
        return {encTab[v / 6], encTab[v % 6]};
    endfunction

    function automatic int refDigit(input logic [2:0] g);
        for (int k = 0; k < 6; k++) begin
            if (encTab[k] == g) return k;
        end
        return -1;
    endfunction

    // Returns -1 when either group is not a legal codeword (decoded value is don't-care).
    function automatic int refDecode(input logic [5:0] w);
        int hi;
        int lo;
        hi = refDigit(w[5:3]);
        lo = refDigit(w[2:0]);
        if (hi < 0 || lo < 0) return -1;
        return hi * 6 + lo;
    endfunction

    function automatic logic refViol(input logic [2:0] g, input logic p);
        if (g == 3'b100 && p == 1'b0) return 1'b1;
        if (g == 3'b011 && p == 1'b1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelReset();
        mV1     = 1'b0;
        mWord   = '0;
        mPrev   = '0;
        eVld    = 1'b0;
        eViol   = '0;
        eData   = 0;
        eCnt    = 0;
        eSticky = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic checkOutputs(input string tag);
        checkOutput({tag, ".data_vld"}, 32'(data_vld), 32'(eVld));
        if (eVld) begin
            checkOutput({tag, ".viol"}, 32'(viol), 32'(eViol));
            if (eData >= 0) checkOutput({tag, ".data_out"}, 32'(data_out), 32'(eData));
        end
        checkOutput({tag, ".err_cnt"}, 32'(err_cnt), 32'(eCnt));
        checkOutput({tag, ".err_sticky"}, 32'(err_sticky), 32'(eSticky));
    endtask

    // Drive one cycle of inputs and advance the model by the edge that follows.
    task automatic applyStimulus(input logic vld, input logic [5:0] word, input logic clr);
        logic [1:0] v;
        tsv_vld = vld;
        tsv_in  = word;
        err_clr = clr;
        if (clr) begin
            eCnt    = 0;
            eSticky = 1'b0;
        end
        if (mV1) begin
            v     = {refViol(mWord[5:3], mPrev[1]), refViol(mWord[2:0], mPrev[0])};
            eVld  = 1'b1;
            eViol = v;
            eData = refDecode(mWord);
            if (!clr && v != 2'b00) begin
                eSticky = 1'b1;
                if (eCnt < CMAX) eCnt++;
            end
            mPrev = {mWord[5], mWord[2]};
        end else begin
            eVld = 1'b0;
        end
        mV1 = vld;
        if (vld) mWord = word;
    endtask

    task automatic step(input string tag, input logic vld, input logic [5:0] word, input logic clr);
        applyStimulus(vld, word, clr);
        @(negedge clock);
        checkOutputs(tag);
    endtask

    initial begin
        rst_n   = 1'b0;
        tsv_in  = '0;
        tsv_vld = 1'b0;
        err_clr = 1'b0;
        modelReset();
        @(negedge clock);
        @(negedge clock);
        checkOutputs("reset");
        checkOutput("reset.data_out", 32'(data_out), 32'd0);
        checkOutput("reset.viol", 32'(viol), 32'd0);
        rst_n = 1'b1;

        // Directed rule checks from a clean prev state.
        step("d0", 1'b1, 6'b100_100, 1'b0);
        step("d1", 1'b1, 6'b100_100, 1'b0);
        checkOutput("first.viol", 32'(viol), 32'b11);
        checkOutput("first.err_cnt", 32'(err_cnt), 32'd1);
        step("d2", 1'b1, 6'b011_011, 1'b0);
        checkOutput("second.viol", 32'(viol), 32'b00);
        step("d3", 1'b1, 6'b011_001, 1'b0);
        checkOutput("third.viol", 32'(viol), 32'b11);
        checkOutput("third.err_cnt", 32'(err_cnt), 32'd2);
        step("d4", 1'b0, 6'b000_000, 1'b0);
        checkOutput("fourth.viol", 32'(viol), 32'b00);
        step("d5", 1'b0, 6'b000_000, 1'b0);
        step("clr0", 1'b0, 6'b000_000, 1'b1);
        step("clr1", 1'b0, 6'b000_000, 1'b0);

        // Legal encoder output never violates and decodes back to the source value.
        for (int i = 0; i < 1000; i++) begin
            step("enc", 1'b1, refEncode(int'($urandom_range(0, 35))), 1'b0);
        end
        step("enc.t0", 1'b0, 6'b000_000, 1'b0);
        step("enc.t1", 1'b0, 6'b000_000, 1'b0);
        checkOutput("enc.err_cnt", 32'(err_cnt), 32'd0);

        // Bubbles must not disturb the previous-word reference.
        step("bub0", 1'b1, 6'b000_100, 1'b0);
        for (int i = 0; i < 3; i++) step("bub.gap", 1'b0, 6'b111_111, 1'b0);
        step("bub1", 1'b1, 6'b000_100, 1'b0);
        step("bub2", 1'b0, 6'b000_000, 1'b0);
        checkOutput("bub.viol0", 32'(viol[0]), 32'd0);

        // Raw random words, random bubbles and occasional clears.
        for (int i = 0; i < 300; i++) begin
            step("rnd", 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                 1'($urandom_range(0, 15) == 0));
        end

        // Saturation: every word after an all-low prev violates in both groups.
        step("sat.pre", 1'b1, 6'b000_000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step("sat", 1'b1, (i % 2 == 0) ? 6'b100_100 : 6'b011_011, 1'b0);
        end
        step("sat.t0", 1'b0, 6'b000_000, 1'b0);
        step("sat.t1", 1'b0, 6'b000_000, 1'b0);
        checkOutput("sat.err_cnt", 32'(err_cnt), 32'd15);

        // Clear coinciding with a violating word landing in stage 2.
        step("cc0", 1'b1, 6'b100_100, 1'b0);
        step("cc1", 1'b0, 6'b000_000, 1'b1);
        checkOutput("cc.viol", 32'(viol), 32'b11);
        checkOutput("cc.err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("cc.err_sticky", 32'(err_sticky), 32'd0);

        // Asynchronous reset while a valid word is on the output.
        step("mr0", 1'b1, 6'b011_011, 1'b0);
        step("mr1", 1'b1, 6'b000_000, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("mr.data_vld", 32'(data_vld), 32'd0);
        checkOutput("mr.data_out", 32'(data_out), 32'd0);
        checkOutput("mr.viol", 32'(viol), 32'd0);
        checkOutput("mr.err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("mr.err_sticky", 32'(err_sticky), 32'd0);
        tsv_vld = 1'b0;
        @(negedge clock);
        checkOutputs("mr.hold");
        rst_n = 1'b1;
        step("mr2", 1'b1, 6'b100_100, 1'b0);
        step("mr3", 1'b0, 6'b000_000, 1'b0);
        checkOutput("mr.after.viol", 32'(viol), 32'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
